// File: rtl/conv_pkg.sv
// Shared constants and types for the convolution stream master.
// The state encoding and word type are kept here so the bench and RTL agree.
package conv_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int N_IN       = 9;
  localparam int N_OUT      = 4;

  typedef enum logic [1:0] {
    LOAD,
    START,
    WAIT,
    DRAIN
  } state_e;

  typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/conv_stream_master.sv
// Streams a 9-word matrix into the 3x3 convolution engine, fires one start
// pulse, captures the 4 results on done and streams them back out with last.
module conv_stream_master
  import conv_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  conv_start,
  output logic [9*DATA_W-1:0]   conv_in,
  input  logic                  conv_done,
  input  logic [4*DATA_W-1:0]   conv_out,
  output logic                  busy,
  output logic                  err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  state_e             state_q;
  logic [DATA_W-1:0]  in_buf_q [N_IN];
  logic [DATA_W-1:0]  res_q    [N_OUT];
  logic [3:0]         idx_q;
  logic [1:0]         k_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;

  // NOTE: every register here, including both buffers, is cleared on reset so
  // a dropped frame can never leak stale words onto conv_in or out_data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_IN; i++)  in_buf_q[i] <= '0;
      for (int j = 0; j < N_OUT; j++) res_q[j]    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // sees the values from the start of the cycle.
      case (state_q)
        LOAD: begin
          if (in_valid) begin
            in_buf_q[idx_q] <= in_data;
            if (idx_q == 4'(N_IN - 1)) begin
              idx_q   <= '0;
              state_q <= START;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        START: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          // done takes priority over a timeout landing on the same cycle
          if (conv_done) begin
            for (int j = 0; j < N_OUT; j++) res_q[j] <= conv_out[j*DATA_W +: DATA_W];
            k_q     <= '0;
            state_q <= DRAIN;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_q   <= 1'b1;
            state_q <= LOAD;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            k_q <= k_q + 1'b1;
            if (k_q == 2'(N_OUT - 1)) state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    conv_in     = '0;
    in_ready    = (state_q == LOAD);
    conv_start  = (state_q == START);
    out_valid   = (state_q == DRAIN);
    busy        = (state_q != LOAD);
    err_timeout = err_q;
    out_data    = out_valid ? res_q[k_q] : '0;
    out_last    = out_valid && (k_q == 2'(N_OUT - 1));
    for (int i = 0; i < N_IN; i++) conv_in[i*DATA_W +: DATA_W] = in_buf_q[i];
  end

endmodule

// File: tb/tb_conv_stream_master.sv
// Frame-level bench for conv_stream_master: table of frames driven through a
// stub engine, with reset, timeout, stale-done and backpressure cases.
module tb_conv_stream_master;

  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic [8:0][DW-1:0] din;
    logic [3:0][DW-1:0] res;
    int                 mode;     // 0 done pulse, 1 done held high, 2 never done
    logic [3:0]         rdy;      // out_ready pattern, bit = drain cycle mod 4
    bit                 gap;      // in_valid bubbles during LOAD
    bit                 exp_err;  // err_timeout expected after the frame
    int                 rst_in;   // reset after this many inputs, -1 never
    int                 rst_out;  // reset after this many results, -1 never
  } vec_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              conv_start;
  logic [9*DW-1:0]   conv_in;
  logic              conv_done;
  logic [4*DW-1:0]   conv_out;
  logic              busy;
  logic              err_timeout;

  int checks   = 0;
  int failures = 0;

  logic [3:0][DW-1:0] stale = {32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
  vec_t vecs [12];

  conv_stream_master #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .conv_start  (conv_start),
    .conv_in     (conv_in),
    .conv_done   (conv_done),
    .conv_out    (conv_out),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int d0, input int step, input int r0, input int mode,
                              input logic [3:0] rdy, input bit gap, input bit err,
                              input int ri, input int ro);
    vec_t v;
    for (int i = 0; i < 9; i++) v.din[i] = 32'(d0 + step * i);
    for (int j = 0; j < 4; j++) v.res[j] = 32'(r0 * (j + 1));
    v.mode = mode; v.rdy = rdy; v.gap = gap; v.exp_err = err;
    v.rst_in = ri; v.rst_out = ro;
    return v;
  endfunction

  // Holds reset low across one rising edge, then checks the idle state.
  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; conv_done = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("rst_in_ready",   in_ready,    1);
    check("rst_busy",       busy,        0);
    check("rst_out_valid",  out_valid,   0);
    check("rst_out_last",   out_last,    0);
    check("rst_out_data",   out_data,    0);
    check("rst_conv_start", conv_start,  0);
    check("rst_conv_in",    conv_in,     0);
    check("rst_err",        err_timeout, 0);
  endtask

  task automatic run_frame(input vec_t v);
    int acc, cyc, c, k, exp_c;
    conv_out  = stale;
    conv_done = (v.mode == 1);
    acc = 0; cyc = 0;
    while (acc < 9 && cyc < 40) begin
      @(negedge clk);
      if (acc == v.rst_in) begin
        do_reset();
        return;
      end
      if (v.gap && (cyc % 2 == 1)) begin
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
      end else begin
        in_valid = 1'b1;
        in_data  = v.din[acc];
        check("in_ready_load", in_ready, 1);
        if (in_ready) acc++;
      end
      cyc++;
    end
    if (acc < 9) begin
      check("load_bound", acc, 9);
      in_valid = 1'b0;
      return;
    end
    // START cycle; junk stays offered to prove nothing is accepted until LOAD
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    check("start_pulse",    conv_start, 1);
    check("start_in_ready", in_ready,   0);
    check("start_busy",     busy,       1);
    check("conv_in",        conv_in,    v.din);
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        check("start_one_cycle", conv_start, 0);
        conv_out = v.res;
      end
      if (v.mode == 0 && c == 2) conv_done = 1'b1;
      if (v.mode == 0 && c == 3) begin
        conv_done = 1'b0;
        conv_out  = stale;
      end
      if (out_valid || in_ready) break;
    end
    conv_done = 1'b0;
    conv_out  = stale;
    exp_c = (v.mode == 0) ? 3 : (v.mode == 1) ? 2 : TO + 1;
    check("wait_latency", c, exp_c);
    if (v.mode == 2) begin
      in_valid = 1'b0;
      check("to_in_ready",  in_ready,    1);
      check("to_out_valid", out_valid,   0);
      check("to_err",       err_timeout, 1);
      check("to_busy",      busy,        0);
      return;
    end
    k = 0; cyc = 0;
    while (k < 4 && cyc < 24) begin
      if (cyc > 0) @(negedge clk);
      if (k == v.rst_out) begin
        do_reset();
        return;
      end
      check("drain_valid",    out_valid, 1);
      check("drain_data",     out_data,  v.res[k]);
      check("drain_last",     out_last,  k == 3);
      check("drain_in_ready", in_ready,  0);
      out_ready = v.rdy[cyc % 4];
      if (out_ready) k++;
      cyc++;
    end
    if (k < 4) check("drain_bound", k, 4);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("end_out_valid", out_valid,   0);
    check("end_in_ready",  in_ready,    1);
    check("end_out_last",  out_last,    0);
    check("end_err",       err_timeout, v.exp_err);
  endtask

  initial begin
    vecs[0]  = mk(1,   1, 10,     0, 4'hF,    0, 0, -1, -1);  // basic
    vecs[1]  = mk(1,   1, 10,     0, 4'hF,    1, 0, -1, -1);  // in_valid gaps
    vecs[2]  = mk(11,  1, 'h111,  0, 4'b1001, 0, 0, -1, -1);  // backpressure
    vecs[3]  = mk(21,  1, 'h222,  1, 4'hF,    0, 0, -1, -1);  // stale done
    vecs[4]  = mk(31,  1, 'h333,  2, 4'hF,    0, 1, -1, -1);  // timeout
    vecs[5]  = mk(41,  1, 'h444,  0, 4'b0110, 0, 1, -1, -1);  // good after timeout
    vecs[6]  = mk(51,  1, 'h555,  0, 4'hF,    0, 0,  5, -1);  // reset in LOAD
    vecs[7]  = mk(61,  1, 'h666,  0, 4'hF,    0, 0, -1,  2);  // reset in DRAIN
    vecs[8]  = mk(9,  -1, 'h777,  0, 4'hF,    0, 0, -1, -1);  // 9..1
    vecs[9]  = mk(100, 3, 'h1000, 0, 4'hF,    0, 0, -1, -1);  // back-to-back
    vecs[10] = mk(200, 5, 'h2000, 0, 4'b1001, 0, 0, -1, -1);
    vecs[11] = mk(300, 7, 'h3000, 1, 4'hF,    0, 0, -1, -1);

    in_data = '0;
    conv_out = '0;
    do_reset();
    for (int f = 0; f < 12; f++) run_frame(vecs[f]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_stream_master.md
# conv_stream_master

Initiator-side controller for the 3x3 matrix convolution engine. It accepts a 9-word input matrix as a valid/ready stream and presents it to the engine as a parallel image. It then issues a one-cycle start, waits for done, captures the 4 result words and returns them as a valid/ready stream with a last marker. It sits between the system data path and the convolution engine, replacing the bench-style driving of start/input/done.

## Interface
Parameters:
- DATA_W, 32, width of every matrix and result word
- TIMEOUT_CYC, 1024, maximum cycles to wait for engine done before aborting a frame

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset); one clock domain, reset sampled on clk
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  DATA_W  input word, row-major order m0..m8
- out_valid  out  1  result word valid
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  result word, order o0..o3
- out_last  out  1  high with o3
- conv_start  out  1  one-cycle start pulse to engine
- conv_in  out  9*DATA_W  packed input matrix, word k at bits [k*DATA_W +: DATA_W]
- conv_done  in  1  engine done (level or pulse)
- conv_out  in  4*DATA_W  packed engine results, word k at bits [k*DATA_W +: DATA_W]
- busy  out  1  high in every state except LOAD
- err_timeout  out  1  sticky, set on timeout abort, cleared only by reset

## Operation
- States: LOAD, START, WAIT, DRAIN.
- **LOAD:**
  - in_ready=1.
  - Each accepted word writes slot idx; idx increments 0..8.
  - Accepting idx=8 clears idx and moves to START.
- **START:**
  - conv_start=1 for exactly this cycle; in_ready=0.
  - Timeout counter cleared; next state WAIT.
- **WAIT:**
  - Counter increments each cycle.
  - If conv_done=1: capture conv_out into the result buffer, set k=0, go to DRAIN.
  - Else, if the counter reaches TIMEOUT_CYC-1: set err_timeout, discard the frame, go to LOAD.
  - If conv_done and the timeout coincide, done wins and no error is set.
- **DRAIN:**
  - out_valid=1, out_data=result[k], out_last=(k==3).
  - On out_ready, k increments. After the handshake on k==3, go to LOAD.
  - out_data and out_last hold stable while out_valid & !out_ready.
- conv_done is ignored outside WAIT, including a stale done during START.
- conv_in is driven from the input buffer at all times. It is stable from START until done is captured, because the buffer is written only in LOAD.
- No arithmetic; words pass through unmodified.
- Reset (reset=0 at an edge), including mid-frame:
  - state=LOAD; idx, k and the counter cleared.
  - Input and result buffers cleared to 0.
  - All outputs 0 except in_ready, which is 1 after reset.
  - err_timeout=0. Any partial frame is dropped.

## Timing
- Input phase: 9 handshakes, minimum 9 cycles.
- conv_start rises in the cycle after the 9th input handshake.
- WAIT is entered one cycle after START. done sampled at edge E gives out_valid=1 in the cycle following E.
- With out_ready tied high, 4 result cycles follow, then in_ready=1 in the next cycle.
- Minimum frame period: 9 + 1 + (engine latency ≥1) + 4 cycles.
- No overlap: the next input is not accepted until the DRAIN of the previous frame completes.

## Structure
- Package conv_pkg holds:
  - DATA_W default
  - N_IN=9 and N_OUT=4 constants
  - typedef enum for the state (LOAD, START, WAIT, DRAIN)
  - typedef for the word type
- Single module with no sub-module. Buffers, counters and the FSM are inline, in one always_ff plus one always_comb.

## Test plan
- **Basic frame:** stream 1..9 with in_valid held. A stub engine asserts done 3 cycles after start with outputs 10,20,30,40. Required:
  - conv_in words equal 1..9.
  - conv_start high for exactly 1 cycle.
  - Outputs 10,20,30,40 in order, out_last only on 40.
- **Backpressure:** out_ready toggles 1,0,0,1,... Each word is held stable until accepted; no duplicates or drops. in_valid gaps during LOAD give the same result.
- **Stale done:** engine holds done=1 continuously, including during START. Capture occurs only in WAIT; results are those present in the first WAIT cycle.
- **Timeout:** TIMEOUT_CYC=16 and the engine never asserts done. err_timeout sets after 16 WAIT cycles, out_valid never rises, in_ready=1 next. A following good frame completes normally and err_timeout stays 1.
- **Reset mid-operation:** assert reset during LOAD after 5 words, and again during DRAIN after 2 results. Required:
  - All outputs reset to 0 and in_ready=1.
  - The next full frame 9..1 produces a correct new result.
- **Back-to-back frames:** three consecutive frames with distinct data. Every result matches its own frame and no input is accepted during START, WAIT or DRAIN.
